// File: rtl/vga_pkg.sv
// vga_pkg
//   Shared types and helpers for the VGA raster generator.
//   - pattern_e : test-pattern select codes carried on mode_i
//   - hmax/vmax : last counter value of a line / frame, derived from the
//                 display, front porch, sync and back porch lengths
package vga_pkg;

  typedef enum logic [1:0] {
    PAT_SOLID    = 2'd0,
    PAT_BARS     = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_GRADIENT = 2'd3
  } pattern_e;

  function automatic int hmax(input int hd, input int hf, input int hr, input int hb);
    return hd + hf + hr + hb - 1;
  endfunction

  function automatic int vmax(input int vd, input int vf, input int vr, input int vb);
    return vd + vf + vr + vb - 1;
  endfunction

endpackage

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Second pipeline stage of the raster generator: turns the registered
//   pixel position into a colour and registers it, blanked outside the
//   active area.
// Ports
//   clk, arst   clock, asynchronous active-high reset
//   pix_ce      pixel tick; state only moves when high
//   mode_i      pattern select (frame-stable shadow copy)
//   color_i     solid colour {R,G,B} (frame-stable shadow copy)
//   de_i        active-pixel flag of the incoming pixel
//   x_i, y_i    position of the incoming pixel (0 outside active area)
//   rgb_o       registered pixel colour, 0 when the pixel was not active
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int  H_BITS     = 11,
  parameter int  V_BITS     = 11,
  parameter int  HD         = 1280,
  parameter int  CB         = 4,
  parameter int  CHECK_LOG2 = 5,
  parameter int  GRAD_SHIFT = 4,
  localparam int RGB_W      = 3 * CB
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              pix_ce,
  input  pattern_e          mode_i,
  input  logic [RGB_W-1:0]  color_i,
  input  logic              de_i,
  input  logic [H_BITS-1:0] x_i,
  input  logic [V_BITS-1:0] y_i,
  output logic [RGB_W-1:0]  rgb_o
);

  localparam int BAR_W = HD / 8;

  logic [2:0]        bar_k_q, bar_k_d;
  logic [H_BITS-1:0] bar_pos_q, bar_pos_d;
  logic [RGB_W-1:0]  rgb_q, rgb_d;
  logic [RGB_W-1:0]  pix_rgb;
  logic [2:0]        level;
  logic [CB-1:0]     grad;
  logic              checker_on;
  logic              last_pixel;

  // bar_k_q/bar_pos_q always describe the pixel currently on x_i. They
  // restart at 0 whenever the next incoming pixel is the start of a line,
  // which replaces a divide by BAR_W. The bar index saturates at 7 so any
  // remainder columns (HD not a multiple of 8) stay in the last bar.
  always_comb begin
    bar_k_d    = bar_k_q;
    bar_pos_d  = bar_pos_q;
    rgb_d      = rgb_q;
    pix_rgb    = '0;
    level      = 3'd7 - bar_k_q;
    grad       = CB'(x_i >> GRAD_SHIFT);
    checker_on = ((H_BITS'(x_i >> CHECK_LOG2) ^ H_BITS'(y_i >> CHECK_LOG2))
                  & H_BITS'(1)) != '0;
    last_pixel = int'(x_i) == HD - 1;

    case (mode_i)
      PAT_SOLID:    pix_rgb = color_i;
      PAT_BARS:     pix_rgb = {{CB{level[2]}}, {CB{level[1]}}, {CB{level[0]}}};
      PAT_CHECKER:  pix_rgb = checker_on ? '1 : '0;
      PAT_GRADIENT: pix_rgb = {3{grad}};
      default:      pix_rgb = '0;
    endcase

    if (pix_ce) begin
      rgb_d = de_i ? pix_rgb : '0;
      if (de_i && !last_pixel) begin
        if (int'(bar_pos_q) == BAR_W - 1) begin
          bar_pos_d = '0;
          if (bar_k_q != 3'd7) begin
            bar_k_d = bar_k_q + 3'd1;
          end
        end else begin
          bar_pos_d = bar_pos_q + 1'b1;
        end
      end else begin
        bar_k_d   = '0;
        bar_pos_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      bar_k_q   <= '0;
      bar_pos_q <= '0;
      rgb_q     <= '0;
    end else begin
      bar_k_q   <= bar_k_d;
      bar_pos_q <= bar_pos_d;
      rgb_q     <= rgb_d;
    end
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/vga_timing_pattern_gen.sv
// vga_timing_pattern_gen
//   VGA raster generator: horizontal/vertical counters, sync and display
//   enable decode, and an internal test-pattern engine. Outputs are the
//   counter position delayed by two pixel ticks, all mutually aligned.
// Ports
//   clk, arst     clock, asynchronous active-high reset
//   pix_ce        pixel tick enable; all state holds while low
//   mode_i        pattern select, sampled once per frame
//   color_i       solid colour {R,G,B}, sampled once per frame
//   vga_hs/vs     sync outputs at HS_POL/VS_POL active level
//   vga_de        active pixel
//   vga_rgb       pixel colour, 0 outside the active area
//   pix_x/pix_y   position of the output pixel, 0 outside the active area
//   frame_start   high while the output pixel is the active (0,0)
module vga_timing_pattern_gen
  import vga_pkg::*;
#(
  parameter int   H_BITS     = 11,
  parameter int   V_BITS     = 11,
  parameter int   HD         = 1280,
  parameter int   HF         = 48,
  parameter int   HR         = 112,
  parameter int   HB         = 248,
  parameter int   VD         = 1024,
  parameter int   VF         = 1,
  parameter int   VR         = 3,
  parameter int   VB         = 38,
  parameter logic HS_POL     = 1'b1,
  parameter logic VS_POL     = 1'b1,
  parameter int   CB         = 4,
  parameter int   CHECK_LOG2 = 5,
  parameter int   GRAD_SHIFT = 4,
  localparam int  RGB_W      = 3 * CB
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              pix_ce,
  input  pattern_e          mode_i,
  input  logic [RGB_W-1:0]  color_i,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de,
  output logic [RGB_W-1:0]  vga_rgb,
  output logic [H_BITS-1:0] pix_x,
  output logic [V_BITS-1:0] pix_y,
  output logic              frame_start
);

  localparam int HMAX = hmax(HD, HF, HR, HB);
  localparam int VMAX = vmax(VD, VF, VR, VB);

  if (HD < 8) begin : g_bad_hd
    $error("vga_timing_pattern_gen: HD must be at least 8");
  end
  if ((2 ** H_BITS) <= HMAX) begin : g_bad_hbits
    $error("vga_timing_pattern_gen: H_BITS too small for line length");
  end
  if ((2 ** V_BITS) <= VMAX) begin : g_bad_vbits
    $error("vga_timing_pattern_gen: V_BITS too small for frame length");
  end

  logic [H_BITS-1:0] h_q, h_d;
  logic [V_BITS-1:0] v_q, v_d;
  logic              first_q, first_d;
  pattern_e          mode_q, mode_d;
  logic [RGB_W-1:0]  color_q, color_d;
  logic              hs1_q, hs1_d, vs1_q, vs1_d, de1_q, de1_d;
  logic [H_BITS-1:0] x1_q, x1_d;
  logic [V_BITS-1:0] y1_q, y1_d;
  logic              hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;
  logic [H_BITS-1:0] x2_q, x2_d;
  logic [V_BITS-1:0] y2_q, y2_d;
  logic              h_last, v_last, h_act, v_act, h_sync, v_sync;

  // Counters, stage-1 decode, stage-2 alignment and shadow registers.
  // The shadows load on the last tick of a frame so the new pattern takes
  // effect exactly at the next (0,0); first_q also loads them on the first
  // tick after reset so a fresh frame uses the current inputs.
  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    first_d = first_q;
    mode_d  = mode_q;
    color_d = color_q;
    hs1_d   = hs1_q;
    vs1_d   = vs1_q;
    de1_d   = de1_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    hs2_d   = hs2_q;
    vs2_d   = vs2_q;
    de2_d   = de2_q;
    x2_d    = x2_q;
    y2_d    = y2_q;

    h_last = int'(h_q) == HMAX;
    v_last = int'(v_q) == VMAX;
    h_act  = int'(h_q) < HD;
    v_act  = int'(v_q) < VD;
    h_sync = (int'(h_q) >= HD + HF) && (int'(h_q) < HD + HF + HR);
    v_sync = (int'(v_q) >= VD + VF) && (int'(v_q) < VD + VF + VR);

    if (pix_ce) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end

      first_d = 1'b0;
      if (first_q || (h_last && v_last)) begin
        mode_d  = mode_i;
        color_d = color_i;
      end

      hs1_d = h_sync ? HS_POL : ~HS_POL;
      vs1_d = v_sync ? VS_POL : ~VS_POL;
      de1_d = h_act && v_act;
      x1_d  = (h_act && v_act) ? h_q : '0;
      y1_d  = (h_act && v_act) ? v_q : '0;

      hs2_d = hs1_q;
      vs2_d = vs1_q;
      de2_d = de1_q;
      x2_d  = x1_q;
      y2_d  = y1_q;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      h_q     <= '0;
      v_q     <= '0;
      first_q <= 1'b1;
      mode_q  <= PAT_SOLID;
      color_q <= '0;
      hs1_q   <= ~HS_POL;
      vs1_q   <= ~VS_POL;
      de1_q   <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      hs2_q   <= ~HS_POL;
      vs2_q   <= ~VS_POL;
      de2_q   <= 1'b0;
      x2_q    <= '0;
      y2_q    <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      first_q <= first_d;
      mode_q  <= mode_d;
      color_q <= color_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      de1_q   <= de1_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      hs2_q   <= hs2_d;
      vs2_q   <= vs2_d;
      de2_q   <= de2_d;
      x2_q    <= x2_d;
      y2_q    <= y2_d;
    end
  end

  vga_pattern_gen #(
    .H_BITS     (H_BITS),
    .V_BITS     (V_BITS),
    .HD         (HD),
    .CB         (CB),
    .CHECK_LOG2 (CHECK_LOG2),
    .GRAD_SHIFT (GRAD_SHIFT)
  ) u_pattern (
    .clk     (clk),
    .arst    (arst),
    .pix_ce  (pix_ce),
    .mode_i  (mode_q),
    .color_i (color_q),
    .de_i    (de1_q),
    .x_i     (x1_q),
    .y_i     (y1_q),
    .rgb_o   (vga_rgb)
  );

  assign vga_hs      = hs2_q;
  assign vga_vs      = vs2_q;
  assign vga_de      = de2_q;
  assign pix_x       = x2_q;
  assign pix_y       = y2_q;
  // Derived from the aligned outputs, so it needs no pipeline of its own.
  assign frame_start = de2_q && (x2_q == '0) && (y2_q == '0);

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// tb_vga_timing_pattern_gen
//   Small-timing raster (16 x 8 total, 8 x 4 active). A behavioural model
//   pushes the expected output for every pixel tick into a queue; the entry
//   popped two ticks later is what the outputs must show until the next
//   tick. A second instance with HS_POL=0 shares all inputs.
module tb_vga_timing_pattern_gen;
  import vga_pkg::*;

  localparam int HD = 8, HF = 2, HR = 3, HB = 3;
  localparam int VD = 4, VF = 1, VR = 2, VB = 1;
  localparam int HMAX = 15, VMAX = 7;
  localparam int BAR_W = 1;

  typedef struct {
    logic        hs;
    logic        hs2;
    logic        vs;
    logic        de;
    logic        fs;
    logic [11:0] rgb;
    logic [10:0] x;
    logic [10:0] y;
  } exp_t;

  logic        clk = 1'b0;
  logic        arst = 1'b0;
  logic        pix_ce = 1'b0;
  pattern_e    mode_i = PAT_SOLID;
  logic [11:0] color_i = 12'hABC;

  logic        vga_hs, vga_vs, vga_de, frame_start;
  logic [11:0] vga_rgb;
  logic [10:0] pix_x, pix_y;
  logic        hs_n, vs_n, de_n, fs_n;
  logic [11:0] rgb_n;
  logic [10:0] x_n, y_n;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t cur;
  int   mh, mv;
  bit   first_m;
  pattern_e    mode_m;
  logic [11:0] color_m;
  bit   ce_on = 1'b0, ce_div3 = 1'b0;
  int   div_cnt = 0;

  vga_timing_pattern_gen #(
    .H_BITS(11), .V_BITS(11),
    .HD(HD), .HF(HF), .HR(HR), .HB(HB),
    .VD(VD), .VF(VF), .VR(VR), .VB(VB),
    .HS_POL(1'b1), .VS_POL(1'b1),
    .CB(4), .CHECK_LOG2(1), .GRAD_SHIFT(1)
  ) dut (
    .clk(clk), .arst(arst), .pix_ce(pix_ce), .mode_i(mode_i), .color_i(color_i),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .vga_rgb(vga_rgb),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
  );

  vga_timing_pattern_gen #(
    .H_BITS(11), .V_BITS(11),
    .HD(HD), .HF(HF), .HR(HR), .HB(HB),
    .VD(VD), .VF(VF), .VR(VR), .VB(VB),
    .HS_POL(1'b0), .VS_POL(1'b1),
    .CB(4), .CHECK_LOG2(1), .GRAD_SHIFT(1)
  ) dut_neg (
    .clk(clk), .arst(arst), .pix_ce(pix_ce), .mode_i(mode_i), .color_i(color_i),
    .vga_hs(hs_n), .vga_vs(vs_n), .vga_de(de_n), .vga_rgb(rgb_n),
    .pix_x(x_n), .pix_y(y_n), .frame_start(fs_n)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t idle_exp();
    exp_t e;
    e.hs = 1'b0; e.hs2 = 1'b1; e.vs = 1'b0; e.de = 1'b0; e.fs = 1'b0;
    e.rgb = '0; e.x = '0; e.y = '0;
    return e;
  endfunction

  function automatic exp_t pixel_exp(input int h, input int v, input pattern_e m, input logic [11:0] c);
    exp_t e;
    int k;
    logic [2:0] lvl;
    logic [3:0] g;
    logic sy;
    e.de  = (h < HD) && (v < VD);
    sy    = (h >= HD + HF) && (h < HD + HF + HR);
    e.hs  = sy;
    e.hs2 = !sy;
    e.vs  = (v >= VD + VF) && (v < VD + VF + VR);
    e.x   = e.de ? 11'(h) : 11'd0;
    e.y   = e.de ? 11'(v) : 11'd0;
    e.fs  = e.de && (h == 0) && (v == 0);
    e.rgb = '0;
    if (e.de) begin
      case (m)
        PAT_SOLID:    e.rgb = c;
        PAT_BARS: begin
          k = h / BAR_W;
          if (k > 7) k = 7;
          lvl = 3'(7 - k);
          e.rgb = {{4{lvl[2]}}, {4{lvl[1]}}, {4{lvl[0]}}};
        end
        PAT_CHECKER:  e.rgb = ((((h >> 1) ^ (v >> 1)) & 1) != 0) ? 12'hFFF : 12'h000;
        PAT_GRADIENT: begin
          g = 4'((h >> 1) & 15);
          e.rgb = {g, g, g};
        end
        default:      e.rgb = '0;
      endcase
    end
    return e;
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; first_m = 1'b1;
    mode_m = PAT_SOLID; color_m = '0;
    exp_q.delete();
    exp_q.push_back(idle_exp());
    cur = idle_exp();
  endtask

  // Scoreboard producer: one entry per pixel tick, consumed two ticks later.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge arst);
      if (arst) begin
        model_reset();
      end else if (pix_ce) begin
        if (first_m || (mh == HMAX && mv == VMAX)) begin
          mode_m  = mode_i;
          color_m = color_i;
        end
        first_m = 1'b0;
        exp_q.push_back(pixel_exp(mh, mv, mode_m, color_m));
        cur = exp_q.pop_front();
        if (mh == HMAX) begin
          mh = 0;
          mv = (mv == VMAX) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
    end
  end

  // Output checker on every falling edge, so ticks and the holds between
  // ticks are both compared.
  initial begin
    forever begin
      @(negedge clk);
      check_output("hs",     vga_hs,      cur.hs);
      check_output("hs_neg", hs_n,        cur.hs2);
      check_output("vs",     vga_vs,      cur.vs);
      check_output("de",     vga_de,      cur.de);
      check_output("rgb",    vga_rgb,     cur.rgb);
      check_output("x",      pix_x,       cur.x);
      check_output("y",      pix_y,       cur.y);
      check_output("fs",     frame_start, cur.fs);
    end
  end

  // Pixel-tick driver: continuous or one tick in three.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (ce_div3) begin
        pix_ce  = (div_cnt == 0);
        div_cnt = (div_cnt + 1) % 3;
      end else begin
        pix_ce = ce_on;
      end
    end
  end

  task automatic wait_pixel(input int x, input int y, input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (vga_de && pix_x == 11'(x) && pix_y == 11'(y)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_pixel(input string tag, input int x, input int y, input logic [11:0] exp);
    bit found;
    wait_pixel(x, y, 600, found);
    if (!found) check_output({tag, "_timeout"}, 32'(found), 32'd1);
    else        check_output(tag, vga_rgb, exp);
  endtask

  task automatic wait_frame_start(input string tag, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (frame_start) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check_output({tag, "_timeout"}, 32'(found), 32'd1);
  endtask

  task automatic apply_stimulus();
    int hs_edge, fs_edge, fs_width;
    logic [10:0] fx, fy;

    // Reset, then release with continuous ticks.
    #1 arst = 1'b1;
    ce_on = 1'b1;
    repeat (3) @(posedge clk);
    #3 arst = 1'b0;
    hs_edge = 0; fs_edge = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      if (frame_start && fs_edge == 0) fs_edge = e;
      if (vga_hs && hs_edge == 0) hs_edge = e;
    end
    check_output("hs_first_rise", 32'(hs_edge), 32'd12);
    check_output("fs_after_release", 32'(fs_edge), 32'd2);
    repeat (260) @(posedge clk);

    // One tick in three: periods stretch, frame_start lasts three clocks.
    ce_div3 = 1'b1;
    wait_frame_start("div3_fs", 1000);
    fs_width = 0;
    while (frame_start && fs_width < 10) begin
      fs_width++;
      @(negedge clk);
    end
    check_output("fs_width_div3", 32'(fs_width), 32'd3);
    repeat (400) @(posedge clk);
    ce_div3 = 1'b0;
    repeat (3) @(posedge clk);

    // Pattern switch mid-frame only takes effect at the next frame.
    check_pixel("solid_3_1", 3, 1, 12'hABC);
    mode_i = PAT_CHECKER;
    check_pixel("solid_rest", 5, 3, 12'hABC);
    check_pixel("chk_0_0", 0, 0, 12'h000);
    check_pixel("chk_2_0", 2, 0, 12'hFFF);
    check_pixel("chk_2_2", 2, 2, 12'h000);

    mode_i = PAT_BARS;
    wait_frame_start("bars_fs", 600);
    check_pixel("bar_x0", 0, 0, 12'hFFF);
    check_pixel("bar_x1", 1, 0, 12'hFF0);
    check_pixel("bar_x2", 2, 0, 12'hF0F);
    check_pixel("bar_x7", 7, 0, 12'h000);
    check_pixel("bar_x1_y3", 1, 3, 12'hFF0);

    mode_i = PAT_GRADIENT;
    wait_frame_start("grad_fs", 600);
    check_pixel("grad_x2", 2, 0, 12'h111);
    check_pixel("grad_x6", 6, 0, 12'h333);
    check_pixel("grad_x6_y3", 6, 3, 12'h333);

    // Mid-line asynchronous reset.
    check_pixel("pre_rst", 4, 1, 12'h222);
    #2 arst = 1'b1;
    #1;
    check_output("rst_hs",     vga_hs,      32'd0);
    check_output("rst_hs_neg", hs_n,        32'd1);
    check_output("rst_vs",     vga_vs,      32'd0);
    check_output("rst_de",     vga_de,      32'd0);
    check_output("rst_rgb",    vga_rgb,     32'd0);
    check_output("rst_x",      pix_x,       32'd0);
    check_output("rst_y",      pix_y,       32'd0);
    check_output("rst_fs",     frame_start, 32'd0);
    @(posedge clk);
    #3 arst = 1'b0;
    fs_edge = 0; fx = 11'h7FF; fy = 11'h7FF;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      if (frame_start && fs_edge == 0) begin
        fs_edge = e;
        fx = pix_x;
        fy = pix_y;
      end
    end
    check_output("fs_after_rst", 32'(fs_edge), 32'd2);
    check_output("x_after_rst", fx, 32'd0);
    check_output("y_after_rst", fy, 32'd0);
    repeat (300) @(posedge clk);
  endtask

  initial begin
    apply_stimulus();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
